apbmst: RTL and testbench
=========================

Name: apbmst

Overview:
- Single-outstanding APB3 initiator (requester side of the APB bus).
- Converts a simple valid/ready request port (CPU or debug side) into APB SETUP/ACCESS transfers toward peripherals such as cpuctrl.
- Returns read data and error status on a one-cycle response pulse.
- Sits between the core's peripheral request path and the APB peripheral select/mux fabric.

Parameters:
- ADDR_W, 12, width of req_addr and apb_paddr.
- TIMEOUT_CYCLES, 255, number of ACCESS cycles with pready low before abort. Used only with the optional feature. Legal range 1..65535.

Ports:
- clk_apb  in  1  APB clock; all logic on its rising edge.
- rst_apb  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  pslverr captured, or timeout.
- apb_psel  out  1  peripheral select.
- apb_penable  out  1  access phase.
- apb_pwrite  out  1  transfer direction.
- apb_paddr  out  ADDR_W  address.
- apb_pwdata  out  32  write data.
- apb_prdata  in  32  read data from peripheral.
- apb_pready  in  1  peripheral ready.
- apb_pslverr  in  1  peripheral error.

Behaviour:
- Reset: all outputs, the state and the timeout counter go to 0; state = IDLE. Takes effect immediately and asynchronously.
- Reset mid-transfer: psel and penable drop at once. The in-flight request is discarded with no rsp_valid.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_write, req_addr and req_wdata into pwrite, paddr and pwdata (pwdata latched for reads as well).
  - Go to SETUP next cycle.
  - Without req_valid, paddr, pwdata and pwrite hold their last values.
- SETUP:
  - psel = 1, penable = 0, req_ready = 0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1. paddr, pwrite and pwdata are stable.
  - pready = 0: stay in ACCESS (wait state).
  - pready = 1: capture the response and go to IDLE. psel and penable drop on the same edge.
- Response capture (registered, presented the cycle after the completing ACCESS cycle):
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = pslverr.
  - rsp_rdata = prdata for reads, 0 for writes.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid is 0 at all other times.
- Zero-wait latency: accept at edge E0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid in cycle 3.
- Back-to-back requests:
  - req_ready returns to 1 in the same cycle that rsp_valid pulses.
  - A request accepted then enters SETUP the next cycle, so psel sits low for exactly one cycle between transfers.
- req_valid or req_addr changes while req_ready = 0 are ignored.
- pready and pslverr are sampled only in ACCESS and ignored in IDLE and SETUP.

Optional Feature:
- Macro: APBMST_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on SETUP entry and increments on each ACCESS cycle with pready = 0.
  - If pready = 0 and counter == TIMEOUT_CYCLES - 1, the transfer aborts: psel and penable drop, state goes to IDLE.
  - The next cycle gives rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - pready = 1 in that same cycle takes priority: normal completion.
- When not defined:
  - No counter exists.
  - ACCESS waits indefinitely for pready.
  - rsp_err reflects only pslverr.

Test Plan:
- Write, zero-wait: req write, addr 0x000, wdata 0x0000_A5A5, pready tied 1 -> psel high 2 cycles, penable in 2nd only, pwdata = 0x0000_A5A5; rsp_valid in cycle 3 with rsp_err = 0, rsp_rdata = 0.
- Read with waits: read addr 0x004, pready low 3 ACCESS cycles then high with prdata 0x1234_5678 -> ACCESS lasts 4 cycles; rsp_rdata = 0x1234_5678, rsp_err = 0; rsp_valid one cycle only.
- Slave error: read addr 0x008, pready = 1, pslverr = 1, prdata 0xDEAD_BEEF -> rsp_err = 1, rsp_rdata = 0xDEAD_BEEF.
- Back-to-back: req_valid held high with write 0x0 then read 0x4 -> second SETUP begins the cycle after rsp_valid; psel low exactly 1 cycle between transfers.
- Reset mid-ACCESS: assert rst_apb while in ACCESS with pready = 0 -> psel, penable and req_ready go 0 at once with no rsp_valid; after release, req_ready = 1 and a new read completes normally.
- Timeout (APBMST_TIMEOUT_EN, TIMEOUT_CYCLES = 4): pready stuck 0 -> exactly 4 ACCESS cycles, then psel drops; rsp_valid with rsp_err = 1, rsp_rdata = 0.

Source files
------------

// File: rtl/apbmst_if.sv
// apbmst_if: request/response and APB bus bundle for apbmst.
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata form the request port,
//   rsp_valid/rsp_rdata/rsp_err form the response pulse, and the apb_* signals
//   form the APB3 bus. The master modport is the initiator view, and slave is
//   the opposite view.
interface apbmst_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [ADDR_W-1:0] apb_paddr;
  logic [31:0]       apb_pwdata;
  logic [31:0]       apb_prdata;
  logic              apb_pready;
  logic              apb_pslverr;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, apb_prdata, apb_pready, apb_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, apb_psel, apb_penable, apb_pwrite,
           apb_paddr, apb_pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, apb_prdata, apb_pready, apb_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, apb_psel, apb_penable, apb_pwrite,
           apb_paddr, apb_pwdata
  );
endinterface

// File: rtl/apbmst.sv
// apbmst: single-outstanding APB3 initiator that turns valid/ready requests into SETUP/ACCESS transfers.
// Ports: clk_apb is the APB clock. rst_apb is the asynchronous active-high reset.
//   bus (apbmst_if.master) carries the request port, the one-cycle response
//   pulse and the APB bus. Every output is a flop.
// Optional: define APBMST_TIMEOUT_EN to abort an ACCESS phase after
//   TIMEOUT_CYCLES cycles with pready low. The abort returns rsp_err = 1.
module apbmst #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk_apb,
  input logic       rst_apb,
  apbmst_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic   accept, done, abort;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apbmst: TIMEOUT_CYCLES out of range 1..65535");
  end
  // req_ready is a flop that is low during reset, so it gates acceptance as well as IDLE.
  assign accept = state == IDLE && bus.req_ready && bus.req_valid;
  assign done   = state == ACCESS && bus.apb_pready;
`ifdef APBMST_TIMEOUT_EN
  logic [15:0] cnt;
  // A late pready wins over the timeout because abort requires pready low.
  assign abort = state == ACCESS && !bus.apb_pready && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_apb or posedge rst_apb)
    if (rst_apb) cnt <= '0;
    else cnt <= accept ? '0 : (state == ACCESS && !bus.apb_pready) ? cnt + 16'd1 : cnt;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (accept ? SETUP : IDLE) :
               state == SETUP ? ACCESS :
               (done || abort) ? IDLE : ACCESS;
  end
  always_ff @(posedge clk_apb or posedge rst_apb) begin
    if (rst_apb) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b0;
      bus.apb_psel    <= 1'b0;
      bus.apb_penable <= 1'b0;
      bus.apb_pwrite  <= 1'b0;
      bus.apb_paddr   <= {ADDR_W{1'b0}};
      bus.apb_pwdata  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.req_ready   <= state_nx == IDLE;
      bus.apb_psel    <= state_nx != IDLE;
      bus.apb_penable <= state_nx == ACCESS;
      bus.rsp_valid   <= done || abort;
      if (accept) begin
        bus.apb_pwrite <= bus.req_write;
        bus.apb_paddr  <= bus.req_addr;
        bus.apb_pwdata <= bus.req_wdata;
      end
      if (done || abort) begin
        bus.rsp_err   <= done ? bus.apb_pslverr : 1'b1;
        bus.rsp_rdata <= (done && !bus.apb_pwrite) ? bus.apb_prdata : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_apbmst.sv
// tb_apbmst: self-checking bench for apbmst using directed and randomized APB transfers.
module tb_apbmst;
  logic clk_apb = 1'b0;
  logic rst_apb = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  apbmst_if #(.ADDR_W(12)) bus ();
  apbmst #(.ADDR_W(12), .TIMEOUT_CYCLES(4)) dut (.clk_apb(clk_apb), .rst_apb(rst_apb), .bus(bus));
  always #5 clk_apb = ~clk_apb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request-side and slave-side noise that the DUT must ignore while busy.
  task automatic scramble();
    bus.req_valid = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_addr  = 12'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // One transfer: waits = ACCESS cycles with pready low before completion.
  // b2b = 1 issues the request in the response cycle of the previous transfer.
  task automatic xfer(input bit w, input logic [11:0] a, input logic [31:0] d,
                      input int waits, input bit e, input logic [31:0] rd, input bit b2b);
    if (!b2b) begin
      @(negedge clk_apb);
      check("idle_ready_rsp", {bus.req_ready, bus.rsp_valid}, 2'b10);
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk_apb);
    check("setup_ctl", {bus.apb_psel, bus.apb_penable, bus.req_ready, bus.rsp_valid}, 4'b1000);
    scramble();
    bus.apb_pready  = 1'($urandom);
    bus.apb_pslverr = 1'($urandom);
    bus.apb_prdata  = $urandom;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk_apb);
      check("access_ctl", {bus.apb_psel, bus.apb_penable, bus.req_ready, bus.rsp_valid}, 4'b1100);
      check("access_addr", bus.apb_paddr, a);
      check("access_dir", bus.apb_pwrite, w);
      check("access_wdata", bus.apb_pwdata, d);
      scramble();
      bus.apb_pready  = (k == waits);
      bus.apb_pslverr = (k == waits) ? e : 1'($urandom);
      bus.apb_prdata  = (k == waits) ? rd : $urandom;
    end
    @(negedge clk_apb);
    check("rsp_ctl", {bus.apb_psel, bus.apb_penable, bus.req_ready, bus.rsp_valid}, 4'b0011);
    check("rsp_rdata", bus.rsp_rdata, w ? 32'd0 : rd);
    check("rsp_err", bus.rsp_err, e);
    bus.req_valid  = 1'b0;
    bus.apb_pready = 1'($urandom);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.apb_prdata  = '0;
    bus.apb_pready  = 1'b0;
    bus.apb_pslverr = 1'b0;
    #1;
    check("reset_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.apb_psel,
                        bus.apb_penable, bus.apb_pwrite}, 6'b0);
    check("reset_paddr", bus.apb_paddr, 0);
    check("reset_pwdata", bus.apb_pwdata, 0);
    check("reset_rdata", bus.rsp_rdata, 0);
    @(negedge clk_apb);
    rst_apb = 1'b0;
    // Directed transfers
    xfer(1'b1, 12'h000, 32'h0000_A5A5, 0, 1'b0, 32'h5555_5555, 1'b0);
    xfer(1'b0, 12'h004, 32'h0BAD_F00D, 3, 1'b0, 32'h1234_5678, 1'b0);
    @(negedge clk_apb);
    check("rsp_one_cycle", bus.rsp_valid, 0);
    xfer(1'b0, 12'h008, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 12'h000, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);
    xfer(1'b0, 12'h004, 32'h3333_4444, 0, 1'b0, 32'hCAFE_0001, 1'b1);
    // Reset during a wait-stated ACCESS phase
    @(negedge clk_apb);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 12'h010;
    @(negedge clk_apb);
    bus.req_valid  = 1'b0;
    bus.apb_pready = 1'b0;
    @(negedge clk_apb);
    check("pre_rst_access", {bus.apb_psel, bus.apb_penable}, 2'b11);
    #1 rst_apb = 1'b1;
    #1;
    check("rst_async_ctl", {bus.apb_psel, bus.apb_penable, bus.req_ready, bus.rsp_valid}, 4'b0000);
    @(negedge clk_apb);
    rst_apb = 1'b0;
    @(negedge clk_apb);
    check("post_rst_ctl", {bus.apb_psel, bus.req_ready, bus.rsp_valid}, 3'b010);
    xfer(1'b0, 12'h014, 32'h0, 1, 1'b0, 32'h0F0F_1234, 1'b1);
`ifdef APBMST_TIMEOUT_EN
    // Stuck slave: four ACCESS cycles, then an error response
    begin
      int n = 0;
      @(negedge clk_apb);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 12'h00C;
      @(negedge clk_apb);
      bus.req_valid  = 1'b0;
      bus.apb_pready = 1'b0;
      bus.apb_prdata = 32'hFFFF_FFFF;
      @(negedge clk_apb);
      while (bus.apb_penable === 1'b1 && n < 20) begin
        n++;
        @(negedge clk_apb);
      end
      check("timeout_cycles", n, 4);
      check("timeout_rsp_ctl", {bus.apb_psel, bus.req_ready, bus.rsp_valid}, 3'b011);
      check("timeout_rdata", bus.rsp_rdata, 0);
      check("timeout_err", bus.rsp_err, 1);
    end
`endif
    // Randomized transfers
    for (int i = 0; i < 30; i++)
      xfer(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 3)),
           1'($urandom), $urandom, (i != 0) && 1'($urandom));
    @(negedge clk_apb);
    check("final_idle", {bus.apb_psel, bus.req_ready, bus.rsp_valid}, 3'b010);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
